// File: rtl/rotate_arbiter.sv
// Round-robin arbiter sharing one left-rotator between NREQ valid/ready requesters,
// with a registered output stage and an optional per-requester burst lock.
module rotate_arbiter #(
   parameter int DW   = 8,
   parameter int SW   = 3,
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*DW-1:0]   req_data,
   input  logic [NREQ*SW-1:0]   req_amt,
   input  logic [NREQ-1:0]      req_lock,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DW-1:0]        out_data,
   output logic [IW-1:0]        out_id,
   output logic                 dbg_state,
   output logic [IW-1:0]        dbg_ptr
);

   // Handshake: a word moves when valid and ready are both high on a rising edge;
   // valid never waits on ready, ready may depend on valid.
   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

   state_e          state_q, state_d;
   logic [IW-1:0]   owner_q, owner_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic            out_valid_q, out_valid_d;
   logic [DW-1:0]   out_data_q, out_data_d;
   logic [IW-1:0]   out_id_q, out_id_d;

   logic            can_load;
   logic            win_any;
   logic [IW-1:0]   win_idx;
   logic            xfer;
   logic [DW-1:0]   sel_data;
   logic [SW-1:0]   sel_amt;
   logic            sel_lock;

   function automatic logic [DW-1:0] rotl(input logic [DW-1:0] a, input logic [SW-1:0] n);
      logic [2*DW-1:0] dbl;
      int unsigned     k;
      k   = 32'(n) % DW;
      dbl = {a, a} << k;
      return dbl[2*DW-1:DW];
   endfunction

   function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
      return (i == IW'(NREQ - 1)) ? '0 : i + 1'b1;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         owner_q     <= '0;
         ptr_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_id_q    <= out_id_d;
      end
   end

   // Winner search: scanning from the highest offset down leaves the lowest offset from ptr.
   always_comb begin
      int idx;
      idx      = 0;
      win_any  = 1'b0;
      win_idx  = '0;
      sel_data = '0;
      sel_amt  = '0;
      sel_lock = 1'b0;
      if (state_q == LOCKED) begin
         win_any = req_valid[owner_q];
         win_idx = owner_q;
      end else begin
         for (int off = NREQ - 1; off >= 0; off--) begin
            idx = (int'(ptr_q) + off) % NREQ;
            if (req_valid[idx]) begin
               win_any = 1'b1;
               win_idx = IW'(idx);
            end
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (win_idx == IW'(i)) begin
            sel_data = req_data[i*DW +: DW];
            sel_amt  = req_amt[i*SW +: SW];
            sel_lock = req_lock[i];
         end
      end
   end

   assign can_load = !out_valid_q || out_ready;
   assign xfer     = win_any && can_load;

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      ptr_d       = ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_id_d    = out_id_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = rotl(sel_data, sel_amt);
         out_id_d    = win_idx;
         case (state_q)
            IDLE: begin
               if (sel_lock) begin
                  state_d = LOCKED;
                  owner_d = win_idx;
               end else begin
                  ptr_d = wrap_inc(win_idx);
               end
            end
            LOCKED: begin
               if (!sel_lock) begin
                  state_d = IDLE;
                  ptr_d   = wrap_inc(owner_q);
               end
            end
            default: state_d = IDLE;
         endcase
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_ready[i] = win_any && (win_idx == IW'(i)) && can_load;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_id    = out_id_q;
   assign dbg_state = state_q;
   assign dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_rotate_arbiter.sv
// Directed bench for rotate_arbiter: grant order, lock bursts, backpressure,
// rotation edge cases (including a DW=6 instance) and asynchronous reset.
module tb_rotate_arbiter;

   localparam int DW = 8, SW = 3, NREQ = 4, IW = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req_valid, req_ready, req_lock;
   logic [NREQ*DW-1:0]  req_data;
   logic [NREQ*SW-1:0]  req_amt;
   logic                out_valid, out_ready, dbg_state;
   logic [DW-1:0]       out_data;
   logic [IW-1:0]       out_id, dbg_ptr;

   logic [1:0]          s_valid, s_ready, s_lock;
   logic [11:0]         s_data;
   logic [5:0]          s_amt;
   logic                s_out_valid, s_out_ready, s_state;
   logic [5:0]          s_out_data;
   logic                s_out_id, s_ptr;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_q[$];
   logic [15:0] exp_w;

   rotate_arbiter #(.DW(DW), .SW(SW), .NREQ(NREQ)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_data(req_data), .req_amt(req_amt), .req_lock(req_lock),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_id(out_id), .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
   );

   rotate_arbiter #(.DW(6), .SW(3), .NREQ(2)) dut6 (
      .clk(clk), .rst(rst), .req_valid(s_valid), .req_ready(s_ready),
      .req_data(s_data), .req_amt(s_amt), .req_lock(s_lock),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
      .out_id(s_out_id), .dbg_state(s_state), .dbg_ptr(s_ptr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic [7:0] d,
                          input logic [2:0] a, input logic l);
      req_valid[i]         = v;
      req_data[i*DW +: DW] = d;
      req_amt[i*SW +: SW]  = a;
      req_lock[i]          = l;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      req_valid = '0; req_lock = '0; req_data = '0; req_amt = '0; out_ready = 1'b0;
      s_valid = '0; s_lock = '0; s_data = '0; s_amt = '0; s_out_ready = 1'b0;
      #1;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_data",  32'(out_data), 0);
      check("rst_out_id",    32'(out_id), 0);
      check("rst_req_ready", 32'(req_ready), 0);
      check("rst_state",     32'(dbg_state), 0);
      check("rst_ptr",       32'(dbg_ptr), 0);
      step();
      rst = 1'b0;

      // single request
      out_ready = 1'b1;
      set_req(1, 1'b1, 8'h81, 3'd1, 1'b0);
      #1;
      check("single_ready", 32'(req_ready), 32'b0010);
      step();
      req_valid = '0;
      check("single_valid", 32'(out_valid), 1);
      check("single_data",  32'(out_data), 32'h03);
      check("single_id",    32'(out_id), 1);

      // round robin with no bubbles
      do_reset();
      set_req(0, 1'b1, 8'h11, 3'd0, 1'b0);
      set_req(1, 1'b1, 8'h22, 3'd1, 1'b0);
      set_req(2, 1'b1, 8'h33, 3'd2, 1'b0);
      set_req(3, 1'b1, 8'h44, 3'd3, 1'b0);
      exp_q.push_back({8'd0, 8'h11});
      exp_q.push_back({8'd1, 8'h44});
      exp_q.push_back({8'd2, 8'hCC});
      exp_q.push_back({8'd3, 8'h22});
      exp_q.push_back({8'd0, 8'h11});
      exp_q.push_back({8'd1, 8'h44});
      while (exp_q.size() > 0) begin
         step();
         exp_w = exp_q.pop_front();
         check("rr_valid", 32'(out_valid), 1);
         check("rr_id",    32'(out_id), 32'(exp_w[15:8]));
         check("rr_data",  32'(out_data), 32'(exp_w[7:0]));
      end

      // backpressure: output held, nobody granted
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("bp_ready", 32'(req_ready), 0);
         check("bp_id",    32'(out_id), 1);
         check("bp_data",  32'(out_data), 32'h44);
         step();
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", 32'(req_ready), 32'b0100);
      step();
      req_valid = '0;
      check("bp_release_id",   32'(out_id), 2);
      check("bp_release_data", 32'(out_data), 32'hCC);
      step();
      check("drain_valid", 32'(out_valid), 0);

      // lock burst from requester 2 while requester 0 waits
      set_req(2, 1'b1, 8'h01, 3'd0, 1'b1);
      step();
      check("lock_b1_id",   32'(out_id), 2);
      check("lock_state",   32'(dbg_state), 1);
      set_req(0, 1'b1, 8'h5A, 3'd0, 1'b0);
      set_req(2, 1'b1, 8'h02, 3'd0, 1'b1);
      #1;
      check("lock_b2_ready", 32'(req_ready), 32'b0100);
      step();
      check("lock_b2_id",   32'(out_id), 2);
      check("lock_b2_data", 32'(out_data), 32'h02);
      set_req(2, 1'b1, 8'h03, 3'd0, 1'b0);
      #1;
      check("lock_b3_ready", 32'(req_ready), 32'b0100);
      step();
      set_req(2, 1'b0, 8'h00, 3'd0, 1'b0);
      check("lock_b3_id",   32'(out_id), 2);
      check("lock_b3_data", 32'(out_data), 32'h03);
      check("unlock_state", 32'(dbg_state), 0);
      #1;
      check("after_lock_ready", 32'(req_ready), 32'b0001);
      step();
      set_req(0, 1'b0, 8'h00, 3'd0, 1'b0);
      check("after_lock_id",   32'(out_id), 0);
      check("after_lock_data", 32'(out_data), 32'h5A);

      // lock owner goes quiet: requester 0 stays blocked
      set_req(2, 1'b1, 8'h0F, 3'd0, 1'b1);
      step();
      set_req(2, 1'b0, 8'h00, 3'd0, 1'b1);
      set_req(0, 1'b1, 8'h77, 3'd0, 1'b0);
      for (int c = 0; c < 3; c++) begin
         #1;
         check("hold_ready", 32'(req_ready), 0);
         check("hold_state", 32'(dbg_state), 1);
         step();
      end
      check("hold_drained", 32'(out_valid), 0);
      set_req(2, 1'b1, 8'hF0, 3'd0, 1'b0);
      step();
      set_req(2, 1'b0, 8'h00, 3'd0, 1'b0);
      check("hold_release_id", 32'(out_id), 2);
      step();
      check("hold_next_id", 32'(out_id), 0);
      set_req(0, 1'b0, 8'h00, 3'd0, 1'b0);
      step();

      // rotation edges, plus DW=6 instance with amount beyond width
      s_out_ready = 1'b1;
      s_valid = 2'b01;
      s_data  = 12'h001;
      s_amt   = 6'd7;
      set_req(0, 1'b1, 8'hA5, 3'd0, 1'b0);
      step();
      s_valid = '0;
      check("rot_a5_0",  32'(out_data), 32'hA5);
      check("rot6_01_7", 32'(s_out_data), 32'h02);
      set_req(0, 1'b1, 8'h01, 3'd7, 1'b0);
      step();
      check("rot_01_7", 32'(out_data), 32'h80);
      set_req(0, 1'b1, 8'h80, 3'd1, 1'b0);
      step();
      check("rot_80_1", 32'(out_data), 32'h01);
      set_req(0, 1'b0, 8'h00, 3'd0, 1'b0);
      step();

      // asynchronous reset while locked with a pending result
      set_req(3, 1'b1, 8'hC3, 3'd0, 1'b1);
      step();
      check("pre_rst_state", 32'(dbg_state), 1);
      check("pre_rst_valid", 32'(out_valid), 1);
      rst = 1'b1;
      #1;
      check("async_rst_valid", 32'(out_valid), 0);
      check("async_rst_state", 32'(dbg_state), 0);
      check("async_rst_data",  32'(out_data), 0);
      step();
      rst = 1'b0;
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 8'(i), 3'd0, 1'b0);
      #1;
      check("post_rst_ready", 32'(req_ready), 32'b0001);
      step();
      check("post_rst_id", 32'(out_id), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
